// File: rtl/bp_pkg.sv
// Shared types, constants and the saturating-counter step for the PHT branch predictor.
package bp_pkg;

    typedef logic [1:0] bp_cnt_t;

    localparam bp_cnt_t BP_CNT_INIT = 2'b10;
    localparam bp_cnt_t BP_CNT_MAX  = 2'b11;
    localparam bp_cnt_t BP_CNT_MIN  = 2'b00;

    typedef enum logic {BP_INIT, BP_RUN} bp_state_t;

    // Saturation is tested before the add/sub so the 2-bit counter never wraps.
    function automatic bp_cnt_t bp_sat_next(input bp_cnt_t cnt, input logic taken);
        bp_cnt_t res;
        if (taken) begin
            res = (cnt == BP_CNT_MAX) ? cnt : bp_cnt_t'(cnt + 2'd1);
        end else begin
            res = (cnt == BP_CNT_MIN) ? cnt : bp_cnt_t'(cnt - 2'd1);
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Pattern history table: 2**IDX_W two-bit counters.
// Registered lookup port returns the pre-write value on a same-edge collision;
// an asynchronous peek port feeds the update read-modify-write so that
// back-to-back updates to one entry chain without a forwarding path.
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output bp_cnt_t          rd_data,
    input  logic [IDX_W-1:0] peek_idx,
    output bp_cnt_t          peek_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  bp_cnt_t          wr_data
);

    localparam int DEPTH = 1 << IDX_W;

    bp_cnt_t mem [DEPTH];

    // Counter storage; contents are established by the controller's init sweep.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Lookup read register; holds its value when no lookup is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= BP_CNT_MIN;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

    assign peek_data = mem[peek_idx];

endmodule

// File: rtl/branch_pred_ctrl.sv
// Branch predictor controller: init/flush sweep FSM, lookup and update indexing,
// and the sweep-versus-update write mux in front of the counter table.
// Optional feature macro: BP_GSHARE_EN (adds a non-speculative global history
// register XORed into both lookup and update indices).
module branch_pred_ctrl
    import bp_pkg::*;
#(
    parameter int PC_W  = 10,
    parameter int IDX_W = 6
) (
    input  logic            BP_CLK,
    input  logic            BP_RST,
    input  logic            BP_FLUSH,
    output logic            BP_READY,
    input  logic            BP_LOOKUP,
    input  logic [PC_W-1:0] BP_LOOKUP_PC,
    output logic            BP_PRED_VALID,
    output logic            BP_PRED_TAKEN,
    output logic [1:0]      BP_PRED_CNT,
    input  logic            BP_UPD_VALID,
    input  logic [PC_W-1:0] BP_UPD_PC,
    input  logic            BP_UPD_TAKEN
);

    bp_state_t        state;
    bp_state_t        state_next;
    logic [IDX_W-1:0] ptr;
    logic             sweep_we;
    logic             lookup_ok;
    logic             upd_ok;
    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] upd_idx;
    bp_cnt_t          rd_data;
    bp_cnt_t          peek_data;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    bp_cnt_t          wr_data;

    // Requests presented alongside a flush are dropped.
    assign lookup_ok = BP_READY & BP_LOOKUP    & ~BP_FLUSH;
    assign upd_ok    = BP_READY & BP_UPD_VALID & ~BP_FLUSH;

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr;

    // Global history shifts in resolved outcomes only (non-speculative).
    always_ff @(posedge BP_CLK or posedge BP_RST) begin
        if (BP_RST) begin
            ghr <= '0;
        end else if (BP_FLUSH) begin
            ghr <= '0;
        end else if (upd_ok) begin
            ghr <= {ghr[IDX_W-2:0], BP_UPD_TAKEN};
        end
    end

    assign lk_idx  = BP_LOOKUP_PC[IDX_W-1:0] ^ ghr;
    assign upd_idx = BP_UPD_PC[IDX_W-1:0] ^ ghr;
`else
    assign lk_idx  = BP_LOOKUP_PC[IDX_W-1:0];
    assign upd_idx = BP_UPD_PC[IDX_W-1:0];
`endif

    // PC bits above the index are deliberately unused: aliasing is accepted.
    generate
        if (PC_W > IDX_W) begin : g_pc_hi
            logic unused_pc_hi;
            assign unused_pc_hi = ^{BP_LOOKUP_PC[PC_W-1:IDX_W], BP_UPD_PC[PC_W-1:IDX_W]};
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge BP_CLK or posedge BP_RST) begin
        if (BP_RST) begin
            state <= BP_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next state: sweep finishes after the last entry; flush always restarts it.
    always_comb begin
        state_next = state;
        case (state)
            BP_INIT: begin
                if (!BP_FLUSH && (ptr == {IDX_W{1'b1}})) begin
                    state_next = BP_RUN;
                end
            end
            BP_RUN: begin
                if (BP_FLUSH) begin
                    state_next = BP_INIT;
                end
            end
            default: state_next = BP_INIT;
        endcase
    end

    // FSM outputs: ready only in RUN, sweep writes every INIT cycle.
    always_comb begin
        BP_READY = 1'b0;
        sweep_we = 1'b0;
        case (state)
            BP_INIT: sweep_we = 1'b1;
            BP_RUN:  BP_READY = 1'b1;
            default: ;
        endcase
    end

    // Sweep pointer; wraps back to zero as the sweep completes.
    always_ff @(posedge BP_CLK or posedge BP_RST) begin
        if (BP_RST) begin
            ptr <= '0;
        end else if (BP_FLUSH) begin
            ptr <= '0;
        end else if (sweep_we) begin
            ptr <= ptr + 1'b1;
        end
    end

    // Write port mux: sweep owns the table during INIT, updates during RUN.
    always_comb begin
        wr_en   = sweep_we | upd_ok;
        wr_idx  = upd_idx;
        wr_data = bp_sat_next(peek_data, BP_UPD_TAKEN);
        if (sweep_we) begin
            wr_idx  = ptr;
            wr_data = BP_CNT_INIT;
        end
    end

    // Prediction valid tracks whether a lookup was accepted last cycle.
    always_ff @(posedge BP_CLK or posedge BP_RST) begin
        if (BP_RST) begin
            BP_PRED_VALID <= 1'b0;
        end else begin
            BP_PRED_VALID <= lookup_ok;
        end
    end

    bp_counter_table #(
        .IDX_W (IDX_W)
    ) u_table (
        .clk       (BP_CLK),
        .rst       (BP_RST),
        .rd_en     (lookup_ok),
        .rd_idx    (lk_idx),
        .rd_data   (rd_data),
        .peek_idx  (upd_idx),
        .peek_data (peek_data),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data)
    );

    assign BP_PRED_CNT   = rd_data;
    assign BP_PRED_TAKEN = rd_data[1];

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed bench for branch_pred_ctrl (PC_W=10, IDX_W=4).
`timescale 1ns/1ps
module tb_branch_pred_ctrl;

    localparam int PC_W  = 10;
    localparam int IDX_W = 4;

    logic            BP_CLK = 1'b0;
    logic            BP_RST;
    logic            BP_FLUSH;
    logic            BP_READY;
    logic            BP_LOOKUP;
    logic [PC_W-1:0] BP_LOOKUP_PC;
    logic            BP_PRED_VALID;
    logic            BP_PRED_TAKEN;
    logic [1:0]      BP_PRED_CNT;
    logic            BP_UPD_VALID;
    logic [PC_W-1:0] BP_UPD_PC;
    logic            BP_UPD_TAKEN;

    int n_assert = 0;
    int n_fail   = 0;

    branch_pred_ctrl #(
        .PC_W  (PC_W),
        .IDX_W (IDX_W)
    ) dut (
        .BP_CLK        (BP_CLK),
        .BP_RST        (BP_RST),
        .BP_FLUSH      (BP_FLUSH),
        .BP_READY      (BP_READY),
        .BP_LOOKUP     (BP_LOOKUP),
        .BP_LOOKUP_PC  (BP_LOOKUP_PC),
        .BP_PRED_VALID (BP_PRED_VALID),
        .BP_PRED_TAKEN (BP_PRED_TAKEN),
        .BP_PRED_CNT   (BP_PRED_CNT),
        .BP_UPD_VALID  (BP_UPD_VALID),
        .BP_UPD_PC     (BP_UPD_PC),
        .BP_UPD_TAKEN  (BP_UPD_TAKEN)
    );

    always #5 BP_CLK = ~BP_CLK;

    task automatic tick();
        @(posedge BP_CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input logic [PC_W-1:0] pc, input logic [1:0] exp_cnt, input string tag);
        BP_LOOKUP    = 1'b1;
        BP_LOOKUP_PC = pc;
        tick();
        BP_LOOKUP = 1'b0;
        $display("lookup pc=%03h valid=%0b cnt=%0d taken=%0b", pc, BP_PRED_VALID, BP_PRED_CNT, BP_PRED_TAKEN);
        check({tag, "_valid"}, 8'(BP_PRED_VALID), 8'd1);
        check({tag, "_cnt"},   8'(BP_PRED_CNT),   8'(exp_cnt));
        check({tag, "_taken"}, 8'(BP_PRED_TAKEN), 8'(exp_cnt[1]));
    endtask

    task automatic update(input logic [PC_W-1:0] pc, input logic taken);
        BP_UPD_VALID = 1'b1;
        BP_UPD_PC    = pc;
        BP_UPD_TAKEN = taken;
        tick();
        BP_UPD_VALID = 1'b0;
        $display("update pc=%03h taken=%0b", pc, taken);
    endtask

    // Expects READY low for `low` more sample points, then high on the next.
    task automatic expect_ready_after(input int low, input string tag);
        for (int i = 0; i < low; i++) begin
            tick();
            check({tag, "_ready_lo"}, 8'(BP_READY), 8'd0);
        end
        tick();
        $display("ready check %s ready=%0b", tag, BP_READY);
        check({tag, "_ready_hi"}, 8'(BP_READY), 8'd1);
    endtask

    initial begin
        BP_RST       = 1'b1;
        BP_FLUSH     = 1'b0;
        BP_LOOKUP    = 1'b0;
        BP_LOOKUP_PC = '0;
        BP_UPD_VALID = 1'b0;
        BP_UPD_PC    = '0;
        BP_UPD_TAKEN = 1'b0;
        tick();
        tick();
        check("rst_ready", 8'(BP_READY),      8'd0);
        check("rst_valid", 8'(BP_PRED_VALID), 8'd0);
        check("rst_cnt",   8'(BP_PRED_CNT),   8'd0);
        check("rst_taken", 8'(BP_PRED_TAKEN), 8'd0);

        // 1. init sweep takes 16 cycles, then weakly-taken everywhere
        BP_RST = 1'b0;
        check("init_ready0", 8'(BP_READY), 8'd0);
        expect_ready_after(15, "init");
        lookup(10'h005, 2'd2, "t1_lk");
        tick();
        check("t1_idle_valid", 8'(BP_PRED_VALID), 8'd0);
        check("t1_idle_hold",  8'(BP_PRED_CNT),   8'd2);

        // 2. not-taken saturates at 0
        update(10'h005, 1'b0);
        update(10'h005, 1'b0);
        update(10'h005, 1'b0);
        lookup(10'h005, 2'd0, "t2_lk");

        // 3. taken saturates at 3
        update(10'h006, 1'b1);
        update(10'h006, 1'b1);
        update(10'h006, 1'b1);
        lookup(10'h006, 2'd3, "t3_lk");

        // 4. same-cycle lookup and update return the old value
        BP_LOOKUP    = 1'b1;
        BP_LOOKUP_PC = 10'h007;
        BP_UPD_VALID = 1'b1;
        BP_UPD_PC    = 10'h007;
        BP_UPD_TAKEN = 1'b0;
        tick();
        BP_LOOKUP    = 1'b0;
        BP_UPD_VALID = 1'b0;
        $display("lookup+update pc=007 cnt=%0d", BP_PRED_CNT);
        check("t4_rbw_cnt", 8'(BP_PRED_CNT), 8'd2);
        lookup(10'h007, 2'd1, "t4_after");

        // 5. flush with concurrent requests re-initialises the table
        update(10'h003, 1'b1);
        update(10'h009, 1'b0);
        lookup(10'h003, 2'd3, "t5_pre3");
        lookup(10'h009, 2'd1, "t5_pre9");
        BP_FLUSH     = 1'b1;
        BP_LOOKUP    = 1'b1;
        BP_LOOKUP_PC = 10'h003;
        BP_UPD_VALID = 1'b1;
        BP_UPD_PC    = 10'h003;
        BP_UPD_TAKEN = 1'b0;
        tick();
        BP_FLUSH     = 1'b0;
        BP_LOOKUP    = 1'b0;
        BP_UPD_VALID = 1'b0;
        $display("flush ready=%0b valid=%0b", BP_READY, BP_PRED_VALID);
        check("t5_flush_valid", 8'(BP_PRED_VALID), 8'd0);
        check("t5_flush_ready", 8'(BP_READY),      8'd0);
        expect_ready_after(15, "t5");
        for (int i = 0; i < 16; i++) begin
            lookup(PC_W'(i), 2'd2, "t5_sweep");
        end

        // 6. aliasing PCs share an entry (or gshare remaps them)
        update(10'h015, 1'b1);
`ifdef BP_GSHARE_EN
        lookup(10'h005, 2'd2, "t6_gs5");
        lookup(10'h004, 2'd3, "t6_gs4");
`else
        lookup(10'h005, 2'd3, "t6_alias");
`endif

        // 7. asynchronous reset mid-operation
        BP_LOOKUP    = 1'b1;
        BP_LOOKUP_PC = 10'h005;
        tick();
        BP_LOOKUP = 1'b0;
        BP_RST    = 1'b1;
        #1;
        $display("async reset ready=%0b valid=%0b cnt=%0d", BP_READY, BP_PRED_VALID, BP_PRED_CNT);
        check("t7_ready", 8'(BP_READY),      8'd0);
        check("t7_valid", 8'(BP_PRED_VALID), 8'd0);
        check("t7_cnt",   8'(BP_PRED_CNT),   8'd0);
        check("t7_taken", 8'(BP_PRED_TAKEN), 8'd0);
        tick();
        BP_RST = 1'b0;

        // 8. flush mid-sweep restarts the 16-cycle sweep; lookups ignored while not ready
        BP_LOOKUP    = 1'b1;
        BP_LOOKUP_PC = 10'h005;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t8_lk_ignored", 8'(BP_PRED_VALID), 8'd0);
        end
        BP_LOOKUP = 1'b0;
        BP_FLUSH  = 1'b1;
        tick();
        BP_FLUSH = 1'b0;
        check("t8_flush_ready", 8'(BP_READY), 8'd0);
        expect_ready_after(15, "t8");
        lookup(10'h005, 2'd2, "t8_lk");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
